pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_redirect_buf.sv | 30 +++
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared fetch-address constants and PC update selector
package pc_unit_pkg;

   // Instruction-address width shared by fetch and decode stages
   localparam int IADDR_W = 32;

   // Defaults for the program-counter unit
   localparam logic [IADDR_W-1:0] DEF_RESET_VEC  = '0;
   localparam int                 DEF_PC_INC     = 4;
   localparam int                 DEF_ALIGN_BITS = 2;

   // Source chosen for the next pc value
   typedef enum logic [2:0] {
      SEL_RESET   = 3'd0,
      SEL_FLUSH   = 3'd1,
      SEL_HOLD    = 3'd2,
      SEL_BRANCH  = 3'd3,
      SEL_PENDING = 3'd4,
      SEL_SEQ     = 3'd5
   } pc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - one-entry pending redirect holding an aligned target
module pc_redirect_buf
   import pc_unit_pkg::*;
#(
   parameter int ADDR_W = IADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              consume,
   input  logic              clear,
   input  logic [ADDR_W-1:0] capture_addr,
   output logic              valid,
   output logic [ADDR_W-1:0] addr
);

   // Clear wins over capture; a new capture overwrites any older entry
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
         addr  <= '0;
      end else if (capture) begin
         valid <= 1'b1;
         addr  <= capture_addr;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with flush, branch and stalled redirect
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                ADDR_W     = IADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
   parameter int                PC_INC     = DEF_PC_INC,
   parameter int                ALIGN_BITS = DEF_ALIGN_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              addr_err
);

   localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

   pc_sel_e           sel;
   logic              err_next;
   logic              pend_capture;
   logic              pend_consume;
   logic              pend_clear;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [ADDR_W-1:0] branch_aligned;
   logic [ADDR_W-1:0] flush_aligned;

   assign branch_aligned = branch_target & ALIGN_MASK;
   assign flush_aligned  = new_pc & ALIGN_MASK;

   pc_redirect_buf #(
      .ADDR_W(ADDR_W)
   ) u_redirect_buf (
      .clk          (clk),
      .rst          (rst),
      .capture      (pend_capture),
      .consume      (pend_consume),
      .clear        (pend_clear),
      .capture_addr (branch_aligned),
      .valid        (pend_valid),
      .addr         (pend_addr)
   );

   // Pick the next pc source by priority and flag misaligned accepted redirects
   always_comb begin
      sel          = SEL_SEQ;
      err_next     = 1'b0;
      pend_capture = 1'b0;
      pend_consume = 1'b0;
      pend_clear   = 1'b0;
      if (!ce) begin
         // Not yet fetching: every request is dropped
         sel = SEL_RESET;
      end else if (flush) begin
         sel        = SEL_FLUSH;
         pend_clear = 1'b1;
         err_next   = |(new_pc & ~ALIGN_MASK);
      end else if (stall) begin
         sel = SEL_HOLD;
         if (branch_flag) begin
            pend_capture = 1'b1;
            err_next     = |(branch_target & ~ALIGN_MASK);
         end
      end else if (branch_flag) begin
         sel        = SEL_BRANCH;
         pend_clear = 1'b1;
         err_next   = |(branch_target & ~ALIGN_MASK);
      end else if (pend_valid) begin
         // Target was aligned and flagged when it was captured
         sel          = SEL_PENDING;
         pend_consume = 1'b1;
      end
   end

   // Register pc, fetch enable and the misalignment pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_VEC;
         ce       <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         ce       <= 1'b1;
         addr_err <= err_next;
         case (sel)
            SEL_RESET:   pc <= RESET_VEC;
            SEL_FLUSH:   pc <= flush_aligned;
            SEL_HOLD:    pc <= pc;
            SEL_BRANCH:  pc <= branch_aligned;
            SEL_PENDING: pc <= pend_addr;
            SEL_SEQ:     pc <= pc + INC;
            default:     pc <= pc;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit against a behavioural model
module tb_pc_unit;

   typedef struct {
      logic [31:0] pc;
      logic        ce;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] pc;
   logic        ce;
   logic        addr_err;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];

   // Reference state: pending redirect kept as a queue of at most one address
   logic [31:0] m_pc;
   logic        m_ce;
   logic [31:0] m_pend[$];

   pc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .flush         (flush),
      .new_pc        (new_pc),
      .pc            (pc),
      .ce            (ce),
      .addr_err      (addr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] align4(input logic [31:0] a);
      return (a / 32'd4) * 32'd4;
   endfunction

   // Advance the model by one edge and record what the DUT must show after it
   task automatic step(input logic r, input logic s, input logic bf, input logic [31:0] bt,
                       input logic f, input logic [31:0] np);
      exp_t e;
      logic err;
      @(negedge clk);
      rst = r; stall = s; branch_flag = bf; branch_target = bt; flush = f; new_pc = np;
      err = 1'b0;
      if (r) begin
         m_pc = 32'h0;
         m_ce = 1'b0;
         m_pend.delete();
      end else if (!m_ce) begin
         m_pc = 32'h0;
         m_ce = 1'b1;
      end else if (f) begin
         m_pc = align4(np);
         m_pend.delete();
         err = (np % 4) != 0;
      end else if (s) begin
         if (bf) begin
            m_pend.delete();
            m_pend.push_back(align4(bt));
            err = (bt % 4) != 0;
         end
      end else if (bf) begin
         m_pc = align4(bt);
         m_pend.delete();
         err = (bt % 4) != 0;
      end else if (m_pend.size() > 0) begin
         m_pc = m_pend.pop_front();
      end else begin
         m_pc = m_pc + 32'd4;
      end
      e.pc = m_pc; e.ce = m_ce; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Look at the result of the edge that follows the most recent step
   task automatic expect_now(input string name, input logic [31:0] want_pc, input logic want_err);
      @(posedge clk);
      #2;
      check({name, "_pc"}, pc, want_pc);
      check({name, "_err"}, {31'h0, addr_err}, {31'h0, want_err});
   endtask

   // Monitor: compare every registered output against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc", pc, e.pc);
            check("sb_ce", {31'h0, ce}, {31'h0, e.ce});
            check("sb_err", {31'h0, addr_err}, {31'h0, e.err});
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0; flush = 1'b0; new_pc = '0;
      m_pc = '0; m_ce = 1'b0;

      // Reset for three cycles, then sequential fetch from the reset vector
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #7;
      check("rst_ce", {31'h0, ce}, 32'h0);
      check("rst_pc", pc, 32'h0);
      idle();
      @(posedge clk); #2;
      check("first_ce", {31'h0, ce}, 32'h1);
      check("first_pc", pc, 32'h0);
      idle(); expect_now("seq4", 32'h4, 1'b0);
      idle(); expect_now("seq8", 32'h8, 1'b0);
      idle(); expect_now("seq12", 32'hC, 1'b0);

      // Unstalled branch
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
      step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0); expect_now("br", 32'h100, 1'b0);
      idle(); expect_now("br_next", 32'h104, 1'b0);

      // Branch captured during a stall, taken when stall falls
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0); expect_now("stall_hold", 32'h20, 1'b0);
      idle(); expect_now("pend_taken", 32'h200, 1'b0);

      // Flush beats stall and branch, and drops the branch
      step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h180); expect_now("flush", 32'h180, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(); expect_now("flush_next", 32'h184, 1'b0);

      // Misaligned branch: aligned target and a single-cycle error pulse
      step(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0); expect_now("mis", 32'h100, 1'b1);
      idle(); expect_now("mis_after", 32'h104, 1'b0);

      // Wrap at the top of the address space
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      idle(); expect_now("wrap", 32'h0, 1'b0);

      // Reset while a redirect is pending; branch during ce=0 is dropped
      step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h503, 1'b0, 32'h0); expect_now("rst_pend", 32'h0, 1'b0);
      idle(); expect_now("rst_pend4", 32'h4, 1'b0);
      idle(); expect_now("rst_pend8", 32'h8, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 63) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom,
              $urandom_range(0, 9) == 0,
              $urandom);
      end
      idle();

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      check("drain", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
